// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// M-extension funct3 encodings and the controller state type.
package md_issue_ctrl_pkg;

  localparam logic [2:0] MD_MUL_FUN3    = 3'b000;
  localparam logic [2:0] MD_MULH_FUN3   = 3'b001;
  localparam logic [2:0] MD_MULHSU_FUN3 = 3'b010;
  localparam logic [2:0] MD_MULHU_FUN3  = 3'b011;
  localparam logic [2:0] MD_DIV_FUN3    = 3'b100;
  localparam logic [2:0] MD_DIVU_FUN3   = 3'b101;
  localparam logic [2:0] MD_REM_FUN3    = 3'b110;
  localparam logic [2:0] MD_REMU_FUN3   = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl.sv
// Issues one M-extension op to the iterative mul/div unit, collects its result
// and presents it to writeback; a flush never abandons the unit mid-operation.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  input  logic [2:0]                  funct3_i,
  input  logic [width_p-1:0]          opA_i,
  input  logic [width_p-1:0]          opB_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  output logic                        ready_o,
  output logic                        illegal_o,
  input  logic                        flush_i,
  output logic                        md_v_o,
  input  logic                        md_ready_i,
  output logic [2:0]                  md_funct3_o,
  output logic [width_p-1:0]          md_opA_o,
  output logic [width_p-1:0]          md_opB_o,
  input  logic                        md_v_i,
  input  logic [width_p-1:0]          md_result_i,
  output logic                        md_yumi_o,
  output logic                        wb_v_o,
  output logic [reg_addr_width_p-1:0] wb_rd_o,
  output logic [width_p-1:0]          wb_data_o,
  input  logic                        wb_yumi_i,
  output logic                        busy_o,
  output logic                        pend_rd_v_o,
  output logic [reg_addr_width_p-1:0] pend_rd_o
);

  md_state_e                   state_q,  state_d;
  logic [2:0]                  funct3_q, funct3_d;
  logic [width_p-1:0]          opA_q,    opA_d;
  logic [width_p-1:0]          opB_q,    opB_d;
  logic [reg_addr_width_p-1:0] rd_q,     rd_d;
  logic [width_p-1:0]          data_q,   data_d;
  logic                        rd_nz_s;

  assign rd_nz_s = (rd_q != {reg_addr_width_p{1'b0}});

  // State and holding registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      opA_q    <= {width_p{1'b0}};
      opB_q    <= {width_p{1'b0}};
      rd_q     <= {reg_addr_width_p{1'b0}};
      data_q   <= {width_p{1'b0}};
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    rd_d     = rd_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (v_i && (funct3_i != MD_MUL_FUN3) && !flush_i) begin
          state_d  = REQ;
          funct3_d = funct3_i;
          opA_d    = opA_i;
          opB_d    = opB_i;
          rd_d     = rd_i;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        if (flush_i)         state_d = IDLE;
        else if (md_ready_i) state_d = WAIT;
        else                 state_d = REQ;
      end
      WAIT: begin
        if (md_v_i) begin
          data_d  = md_result_i;
          // A flushed op or an x0 destination consumes the result without writeback.
          state_d = (flush_i || !rd_nz_s) ? IDLE : WB;
        end else if (flush_i) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (md_v_i) state_d = IDLE;
        else        state_d = DRAIN;
      end
      WB: begin
        if (wb_yumi_i || flush_i) state_d = IDLE;
        else                      state_d = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign illegal_o   = v_i & (funct3_i == MD_MUL_FUN3) & (state_q == IDLE);
  assign md_v_o      = (state_q == REQ);
  assign md_funct3_o = funct3_q;
  assign md_opA_o    = opA_q;
  assign md_opB_o    = opB_q;
  assign md_yumi_o   = md_v_i & ((state_q == WAIT) | (state_q == DRAIN));
  assign wb_v_o      = (state_q == WB);
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = data_q;
  assign pend_rd_v_o = rd_nz_s & ((state_q == REQ) | (state_q == WAIT) | (state_q == WB));
  assign pend_rd_o   = rd_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: the bench plays the mul/div unit and the
// writeback arbiter; expected writebacks are queued at accept and popped at grant.
module tb_md_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [2:0]  funct3_i;
  logic [31:0] opA_i, opB_i;
  logic [4:0]  rd_i;
  logic        ready_o, illegal_o, flush_i;
  logic        md_v_o, md_ready_i;
  logic [2:0]  md_funct3_o;
  logic [31:0] md_opA_o, md_opB_o;
  logic        md_v_i;
  logic [31:0] md_result_i;
  logic        md_yumi_o, wb_v_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_yumi_i, busy_o, pend_rd_v_o;
  logic [4:0]  pend_rd_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int total  = 0;
  int passed = 0;
  int failed = 0;

  md_issue_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .funct3_i(funct3_i),
    .opA_i(opA_i), .opB_i(opB_i), .rd_i(rd_i), .ready_o(ready_o),
    .illegal_o(illegal_o), .flush_i(flush_i), .md_v_o(md_v_o),
    .md_ready_i(md_ready_i), .md_funct3_o(md_funct3_o), .md_opA_o(md_opA_o),
    .md_opB_o(md_opB_o), .md_v_i(md_v_i), .md_result_i(md_result_i),
    .md_yumi_o(md_yumi_o), .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_yumi_i(wb_yumi_i), .busy_o(busy_o),
    .pend_rd_v_o(pend_rd_v_o), .pend_rd_o(pend_rd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present an op in IDLE and take the accept edge; leaves the DUT in REQ.
  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    v_i = 1'b1; funct3_i = f3; opA_i = a; opB_i = b; rd_i = rd;
    #1;
    check("acc_ready", {31'd0, ready_o}, 32'd1);
    check("acc_illegal", {31'd0, illegal_o}, 32'd0);
    step();
    v_i = 1'b0; opA_i = 32'hDEAD_BEEF; opB_i = 32'hDEAD_BEEF; rd_i = 5'd31;
    check("req_md_v", {31'd0, md_v_o}, 32'd1);
    check("req_ready", {31'd0, ready_o}, 32'd0);
    check("req_funct3", {29'd0, md_funct3_o}, {29'd0, f3});
    check("req_opA", md_opA_o, a);
    check("req_opB", md_opB_o, b);
    check("req_pend_v", {31'd0, pend_rd_v_o}, {31'd0, (rd != 5'd0)});
    check("req_pend_rd", {27'd0, pend_rd_o}, {27'd0, rd});
  endtask

  // Hold md_ready_i low for 'stall' cycles, then handshake; leaves DUT in WAIT.
  task automatic handshake(input int stall, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_md_v", {31'd0, md_v_o}, 32'd1);
      check("stall_opA", md_opA_o, a);
      check("stall_opB", md_opB_o, b);
    end
    md_ready_i = 1'b1;
    step();
    md_ready_i = 1'b0;
    check("wait_md_v", {31'd0, md_v_o}, 32'd0);
    check("wait_busy", {31'd0, busy_o}, 32'd1);
  endtask

  // Full op with writeback expected when rd != 0.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int stall, input int lat,
                        input logic [31:0] res);
    wb_exp_t e;
    wb_exp_t got;
    accept(f3, a, b, rd);
    if (rd != 5'd0) begin
      e.rd = rd; e.data = res;
      sb_q.push_back(e);
    end
    handshake(stall, a, b);
    for (int i = 0; i < lat; i++) begin
      check("wait_yumi", {31'd0, md_yumi_o}, 32'd0);
      check("wait_wb_v", {31'd0, wb_v_o}, 32'd0);
      check("wait_pend_v", {31'd0, pend_rd_v_o}, {31'd0, (rd != 5'd0)});
      step();
    end
    md_v_i = 1'b1; md_result_i = res;
    #1;
    check("res_yumi", {31'd0, md_yumi_o}, 32'd1);
    step();
    md_v_i = 1'b0; md_result_i = 32'h0;
    check("post_yumi", {31'd0, md_yumi_o}, 32'd0);
    if (rd != 5'd0) begin
      check("wb_v", {31'd0, wb_v_o}, 32'd1);
      check("wb_sb_nonempty", sb_q.size(), 32'd1);
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("wb_v_hold", {31'd0, wb_v_o}, 32'd1);
          check("wb_rd", {27'd0, wb_rd_o}, {27'd0, got.rd});
          check("wb_data", wb_data_o, got.data);
          check("wb_ready", {31'd0, ready_o}, 32'd0);
          if (i < 2) step();
        end
      end
      wb_yumi_i = 1'b1;
      step();
      wb_yumi_i = 1'b0;
    end else begin
      check("x0_wb_v", {31'd0, wb_v_o}, 32'd0);
      check("x0_pend_v", {31'd0, pend_rd_v_o}, 32'd0);
    end
    check("done_ready", {31'd0, ready_o}, 32'd1);
    check("done_wb_v", {31'd0, wb_v_o}, 32'd0);
    check("done_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b1; funct3_i = 3'b000; opA_i = 32'h0; opB_i = 32'h0;
    rd_i = 5'd0; flush_i = 1'b0; md_ready_i = 1'b0; md_v_i = 1'b0;
    md_result_i = 32'h0; wb_yumi_i = 1'b0;
    #3;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_md_v", {31'd0, md_v_o}, 32'd0);
    check("rst_wb_v", {31'd0, wb_v_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_pend_v", {31'd0, pend_rd_v_o}, 32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd1);
    check("rst_opA", md_opA_o, 32'h0);
    step();
    reset_i = 1'b0; v_i = 1'b0;
    step();

    // DIVU 100/7 -> 14, unit answers after 33 cycles
    run_op(3'b101, 32'd100, 32'd7, 5'd5, 0, 32, 32'd14);
    // MULH with 4 stall cycles on md_ready_i
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd3, 4, 2, 32'hFFFF_FFFF);

    // MUL low presented: illegal, never issued
    v_i = 1'b1; funct3_i = 3'b000; opA_i = 32'd9; rd_i = 5'd4;
    #1;
    check("ill_illegal", {31'd0, illegal_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ill_ready", {31'd0, ready_o}, 32'd1);
      check("ill_md_v", {31'd0, md_v_o}, 32'd0);
    end
    v_i = 1'b0;
    #1;
    check("ill_drop", {31'd0, illegal_o}, 32'd0);

    // REM to x0: result consumed, no writeback
    run_op(3'b110, 32'd17, 32'd5, 5'd0, 0, 3, 32'd2);

    // Flush in WAIT at cycle 5, unit result at cycle 20
    accept(3'b100, 32'd50, 32'd3, 5'd7);
    handshake(0, 32'd50, 32'd3);
    step(); step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int c = 6; c < 20; c++) begin
      check("drain_busy", {31'd0, busy_o}, 32'd1);
      check("drain_pend_v", {31'd0, pend_rd_v_o}, 32'd0);
      check("drain_yumi", {31'd0, md_yumi_o}, 32'd0);
      check("drain_ready", {31'd0, ready_o}, 32'd0);
      step();
    end
    md_v_i = 1'b1; md_result_i = 32'd16;
    #1;
    check("drain_res_yumi", {31'd0, md_yumi_o}, 32'd1);
    step();
    md_v_i = 1'b0;
    check("drain_done_ready", {31'd0, ready_o}, 32'd1);
    check("drain_no_wb", {31'd0, wb_v_o}, 32'd0);

    // Flush together with md_v_i in WAIT: consumed, no writeback
    accept(3'b111, 32'd9, 32'd4, 5'd8);
    handshake(0, 32'd9, 32'd4);
    flush_i = 1'b1; md_v_i = 1'b1; md_result_i = 32'd1;
    #1;
    check("fv_yumi", {31'd0, md_yumi_o}, 32'd1);
    step();
    flush_i = 1'b0; md_v_i = 1'b0;
    check("fv_ready", {31'd0, ready_o}, 32'd1);
    check("fv_wb_v", {31'd0, wb_v_o}, 32'd0);

    // Flush and md_ready_i in the same REQ cycle: no request issued
    accept(3'b010, 32'd1, 32'd2, 5'd9);
    flush_i = 1'b1; md_ready_i = 1'b1;
    step();
    flush_i = 1'b0; md_ready_i = 1'b0;
    check("frq_ready", {31'd0, ready_o}, 32'd1);
    check("frq_md_v", {31'd0, md_v_o}, 32'd0);
    check("frq_busy", {31'd0, busy_o}, 32'd0);

    // Flush in WB drops the result
    accept(3'b011, 32'd6, 32'd7, 5'd10);
    handshake(0, 32'd6, 32'd7);
    md_v_i = 1'b1; md_result_i = 32'd42;
    step();
    md_v_i = 1'b0;
    check("fwb_wb_v", {31'd0, wb_v_o}, 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fwb_drop", {31'd0, wb_v_o}, 32'd0);
    check("fwb_ready", {31'd0, ready_o}, 32'd1);

    // Async reset while in WB
    accept(3'b100, 32'd8, 32'd2, 5'd11);
    handshake(0, 32'd8, 32'd2);
    md_v_i = 1'b1; md_result_i = 32'd4;
    step();
    md_v_i = 1'b0;
    check("arst_pre_wb_v", {31'd0, wb_v_o}, 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_wb_v", {31'd0, wb_v_o}, 32'd0);
    check("arst_ready", {31'd0, ready_o}, 32'd1);
    check("arst_pend_v", {31'd0, pend_rd_v_o}, 32'd0);
    check("arst_data", wb_data_o, 32'h0);
    step();
    reset_i = 1'b0;
    step();

    // Back-to-back op after reset still works
    run_op(3'b101, 32'hFFFF_FFF0, 32'd16, 5'd31, 1, 5, 32'h0FFF_FFFF);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
